// File: rtl/spi_pkg.sv
// Shared constants for the SPI initiator: frame layout, peripheral register map
// and controller state encoding.
package spi_pkg;

  localparam int FRAME_W  = 16;
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  localparam logic [6:0] EN_OUT_7_0  = 7'd0;
  localparam logic [6:0] EN_OUT_15_8 = 7'd1;
  localparam logic [6:0] EN_PWM_7_0  = 7'd2;
  localparam logic [6:0] EN_PWM_15_8 = 7'd3;
  localparam logic [6:0] PWM_DUTY    = 7'd4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LEAD  = ST_LEAD,
    SHIFT = ST_SHIFT,
    TRAIL = ST_TRAIL,
    GAP   = ST_GAP
  } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: pulses tick every CLK_DIV enabled cycles,
// restarting from zero whenever clr is high or the divider is disabled.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = en && !clr && (cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// Mode-0, MSB-first SPI initiator sending 16-bit {rw, addr, data} frames with
// generous nCS lead/trail/gap margins for a synchronising peripheral.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       CIPO,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI
);

  state_t               state, state_n;
  logic [FRAME_W-1:0]   shift_reg, shift_n;
  logic [7:0]           rx_reg, rx_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic                 gap_half, gap_half_n;
  logic                 busy_n, done_n, ncs_n, sclk_n, copi_n;
  logic [7:0]           rdata_n;
  logic                 tick, div_en, div_clr;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .clr  (div_clr),
    .tick (tick)
  );

  assign div_en = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      rx_reg    <= '0;
      bit_cnt   <= '0;
      gap_half  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      nCS       <= 1'b1;
      SCLK      <= 1'b0;
      COPI      <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      rx_reg    <= rx_n;
      bit_cnt   <= bit_cnt_n;
      gap_half  <= gap_half_n;
      busy      <= busy_n;
      done      <= done_n;
      rdata     <= rdata_n;
      nCS       <= ncs_n;
      SCLK      <= sclk_n;
      COPI      <= copi_n;
    end
  end

  always_comb begin
    state_n    = state;
    shift_n    = shift_reg;
    rx_n       = rx_reg;
    bit_cnt_n  = bit_cnt;
    gap_half_n = gap_half;
    busy_n     = busy;
    done_n     = 1'b0;
    rdata_n    = rdata;
    ncs_n      = nCS;
    sclk_n     = SCLK;
    copi_n     = COPI;
    div_clr    = 1'b0;

    case (state)
      IDLE: begin
        div_clr = 1'b1;
        // The cycle carrying the done pulse never accepts a new request.
        if (start && !done) begin
          shift_n[RW_BIT]            = rw;
          shift_n[ADDR_MSB:ADDR_LSB] = addr;
          shift_n[DATA_MSB:0]        = wdata;
          copi_n     = rw;
          ncs_n      = 1'b0;
          busy_n     = 1'b1;
          bit_cnt_n  = '0;
          gap_half_n = 1'b0;
          state_n    = LEAD;
        end
      end
      LEAD: begin
        if (tick) begin
          sclk_n  = 1'b1;
          rx_n    = {rx_reg[6:0], CIPO};
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!SCLK) begin
            sclk_n = 1'b1;
            rx_n   = {rx_reg[6:0], CIPO};
          end else begin
            sclk_n = 1'b0;
            if (bit_cnt != 4'd15) begin
              shift_n   = {shift_reg[FRAME_W-2:0], 1'b0};
              copi_n    = shift_reg[FRAME_W-2];
              bit_cnt_n = bit_cnt + 4'd1;
            end else begin
              rdata_n = rx_reg;
              state_n = TRAIL;
            end
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          ncs_n   = 1'b1;
          copi_n  = 1'b0;
          state_n = GAP;
        end
      end
      GAP: begin
        // Two divider periods of nCS high before reporting completion.
        if (tick) begin
          if (!gap_half) begin
            gap_half_n = 1'b1;
          end else begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboarded bench for spi_controller: stimulus queues expected frames, a pin
// monitor acting as the peripheral reconstructs frames and checks timing.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       CIPO = 1'b0;
  logic       busy, done, nCS, SCLK, COPI;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .rw    (rw),
    .addr  (addr),
    .wdata (wdata),
    .CIPO  (CIPO),
    .busy  (busy),
    .done  (done),
    .rdata (rdata),
    .nCS   (nCS),
    .SCLK  (SCLK),
    .COPI  (COPI)
  );

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  cb;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_mon;
  int         checks = 0;
  int         errors = 0;
  int         dones = 0;
  logic [7:0] regs [0:127];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Pin monitor / peripheral model
  logic       p_sclk = 1'b0, p_ncs = 1'b1, p_copi = 1'b0;
  int         rises = 0, low_cnt = 0, gap = 0, high_cnt = 0;
  logic [15:0] fbits = '0;
  logic       copi_bad = 1'b0, rdata_bad = 1'b0, seen_frame = 1'b0;
  logic [7:0] model_rdata = '0, cur_cb = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (done) check("done_in_reset", 32'(done), 32'd0);
      p_sclk = 1'b0; p_ncs = 1'b1; p_copi = 1'b0;
      rises = 0; low_cnt = 0; gap = 0; high_cnt = 0;
      copi_bad = 1'b0; rdata_bad = 1'b0; seen_frame = 1'b0;
      model_rdata = '0; CIPO = 1'b0;
    end else begin
      if (!nCS && p_ncs) begin
        if (seen_frame) check("ncs_high_between", 32'(high_cnt >= 2*D), 32'd1);
        rises = 0; low_cnt = 0; fbits = '0; copi_bad = 1'b0; rdata_bad = 1'b0;
        cur_cb = (exp_q.size() > 0) ? exp_q[0].cb : 8'h00;
        CIPO = 1'($urandom_range(0, 1));
      end
      if (!nCS) begin
        low_cnt++;
        if (COPI != p_copi && !p_ncs && !(p_sclk && !SCLK)) copi_bad = 1'b1;
        if (!(rises == 16 && !SCLK) && rdata !== model_rdata) rdata_bad = 1'b1;
        if (SCLK && !p_sclk) begin
          fbits = {fbits[14:0], COPI};
          rises++;
          if (rises >= 8 && rises <= 15) CIPO = cur_cb[15 - rises];
          else CIPO = 1'($urandom_range(0, 1));
        end
      end
      if (nCS && !p_ncs) begin
        check("ncs_low_cycles", 32'(low_cnt), 32'(33*D));
        check("sclk_rises", 32'(rises), 32'd16);
        if (rises == 16 && fbits[15]) regs[fbits[14:8]] = fbits[7:0];
        gap = 0; high_cnt = 1; seen_frame = 1'b1; CIPO = 1'b0;
      end else if (nCS) begin
        gap++; high_cnt++;
      end
      if (done) begin
        dones++;
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          e_mon = exp_q.pop_front();
          check("frame_bits", 32'(fbits), 32'(e_mon.frame));
          check("rdata", 32'(rdata), 32'(e_mon.cb));
          check("done_after_ncs_rise", 32'(gap), 32'(2*D));
          check("copi_only_on_fall", 32'(copi_bad), 32'd0);
          check("rdata_stable_in_frame", 32'(rdata_bad), 32'd0);
          model_rdata = e_mon.cb;
        end
      end
      p_sclk = SCLK; p_ncs = nCS; p_copi = COPI;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input logic r, input logic [6:0] a, input logic [7:0] w, input logic [7:0] cb);
    exp_t e;
    wait_idle();
    e.frame = {r, a, w};
    e.cb = cb;
    exp_q.push_back(e);
    rw = r; addr = a; wdata = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accepted", 32'(busy), 32'd1);
    rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   d0, n;
    logic ps;
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_ncs", 32'(nCS), 32'd1);
    check("rst_sclk", 32'(SCLK), 32'd0);
    check("rst_copi", 32'(COPI), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;

    send(1'b1, EN_OUT_7_0, 8'hA5, 8'($urandom));
    wait_idle();
    check("reg_en_out_7_0", 32'(regs[EN_OUT_7_0]), 32'h A5);

    // Back-to-back with start held high
    wait_idle();
    e.frame = {1'b1, PWM_DUTY, 8'h80}; e.cb = 8'($urandom); exp_q.push_back(e);
    rw = 1'b1; addr = PWM_DUTY; wdata = 8'h80; start = 1'b1;
    d0 = dones;
    @(negedge clk);
    check("b2b_first_accept", 32'(busy), 32'd1);
    e.frame = {1'b1, EN_PWM_7_0, 8'hFF}; e.cb = 8'($urandom); exp_q.push_back(e);
    addr = EN_PWM_7_0; wdata = 8'hFF;
    n = 0;
    while (!(busy && dones > d0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("b2b_second_accept", 32'(n < 2000), 32'd1);
    wait_idle();
    check("reg_pwm_duty", 32'(regs[PWM_DUTY]), 32'h80);
    check("reg_en_pwm_7_0", 32'(regs[EN_PWM_7_0]), 32'hFF);

    send(1'b0, EN_OUT_15_8, 8'h3C, 8'($urandom));
    wait_idle();
    check("read_no_write", 32'(regs[EN_OUT_15_8]), 32'h00);

    send(1'b0, EN_PWM_15_8, 8'h00, 8'h5A);
    wait_idle();
    check("rdata_5a", 32'(rdata), 32'h5A);
    send(1'b0, EN_PWM_15_8, 8'h00, 8'hC3);

    // Start pulsed while busy must be ignored
    d0 = dones;
    repeat (40) @(negedge clk);
    rw = 1'b1; addr = 7'h10; wdata = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check("ignored_start_done_count", 32'(dones - d0), 32'd1);
    check("ignored_start_no_write", 32'(regs[7'h10]), 32'h00);

    // Reset at the 7th SCLK rise
    send(1'b1, EN_PWM_15_8, 8'h77, 8'($urandom));
    n = 0; ps = SCLK; d0 = 0;
    while (d0 < 7 && n < 2000) begin
      @(posedge clk);
      #1;
      if (SCLK && !ps) d0++;
      ps = SCLK;
      n++;
    end
    check("reached_7th_rise", 32'(d0), 32'd7);
    rst = 1'b1;
    #1;
    check("abort_ncs", 32'(nCS), 32'd1);
    check("abort_sclk", 32'(SCLK), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    d0 = dones;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_no_done", 32'(dones - d0), 32'd0);
    check("abort_no_write", 32'(regs[EN_PWM_15_8]), 32'h00);
    send(1'b1, EN_PWM_15_8, 8'h11, 8'($urandom));
    wait_idle();
    check("post_abort_write", 32'(regs[EN_PWM_15_8]), 32'h11);

    for (int i = 0; i < 12; i++) begin
      send(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI initiator that drives the on-chip SPI peripheral register block (and the same pins off-chip), mode 0, MSB first.
- Takes one-shot requests for 16-bit frames {rw, addr[6:0], data[7:0]} and generates nCS, SCLK and COPI with enough margin for the peripheral's two-flop synchronisers.
- Optionally captures CIPO during the data phase.
- Used by the test harness and the management logic to program the output-enable, PWM-enable and duty-cycle registers.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 3..255.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a frame; sampled only when busy=0.
- rw  input  1  frame bit 15; 1 = write (peripheral updates the register).
- addr  input  7  register address, frame bits 14:8.
- wdata  input  8  write data, frame bits 7:0.
- CIPO  input  1  serial data from the peripheral, sampled on the SCLK rising edge.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-clk pulse when a frame completes.
- rdata  output  8  last 8 CIPO bits of the most recent frame.
- nCS  output  1  active-low chip select.
- SCLK  output  1  serial clock, idle low.
- COPI  output  1  serial data to the peripheral.

Behaviour:
- Reset values (asynchronous): nCS=1, SCLK=0, COPI=0, busy=0, done=0, rdata=0, state=IDLE, all counters 0.
- Reset mid-frame aborts the frame immediately; no done pulse.
- All outputs are registered; no combinational path from inputs to pins.
- State machine: IDLE, LEAD, SHIFT, TRAIL, GAP.
- IDLE:
  - On start=1 at edge N: load shift register {rw,addr,wdata}, COPI<=rw, nCS<=0, busy<=1, go to LEAD. Outputs change after edge N.
  - start while busy=1 is ignored (no queueing). Inputs are captured only at the accept edge.
- LEAD: hold CLK_DIV cycles after nCS falls, then SCLK<=1 (first rising edge, bit 15 stable for ≥CLK_DIV cycles). Go to SHIFT.
- SHIFT:
  - A divider counter 0..CLK_DIV-1 toggles SCLK at terminal count. Bit counter runs 0..15.
  - On each rising toggle: rx shift <= {rx[6:0], CIPO}.
  - On each falling toggle with bit_cnt<15: shift, COPI <= next bit, bit_cnt++.
  - On the falling toggle with bit_cnt==15: rdata <= rx, go to TRAIL. SCLK stays low.
  - Exactly 16 rising edges per frame; COPI changes only on falling edges (plus the initial load).
- TRAIL: CLK_DIV cycles after the last falling edge, nCS<=1, COPI<=0. Go to GAP.
- GAP:
  - nCS held high for 2*CLK_DIV cycles so the peripheral finishes its latch step and returns to idle.
  - Then done<=1 for one cycle, busy<=0, go to IDLE.
  - start is not accepted in the done cycle; the earliest next accept is the cycle after.
- Timing:
  - nCS low for exactly 33*CLK_DIV cycles (lead + 31 half-periods + trail).
  - done is asserted 2*CLK_DIV cycles after nCS rises.
  - With CLK_DIV=4: nCS low 132 cycles; done 8 cycles after nCS rises.
- Width rules: divider counter 8 bits, bit counter 4 bits, no wrap beyond 15.
- A frame with rw=0 is still fully clocked; the peripheral ignores the data.

Decomposition:
- Package spi_pkg holds:
  - FRAME_W=16, field positions (RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7).
  - Register address constants: EN_OUT_7_0=0, EN_OUT_15_8=1, EN_PWM_7_0=2, EN_PWM_15_8=3, PWM_DUTY=4.
  - State encoding localparams.
- One sub-module, spi_clk_div: CLK_DIV half-period tick generator with enable and synchronous clear. The FSM stays in spi_controller.

Test Plan:
- Reset, then start with rw=1, addr=0x00, wdata=0xA5, CLK_DIV=4 -> COPI samples at the 16 SCLK rises = 1,0000000,10100101; nCS low 132 cycles; done one cycle; peripheral en_reg_out_7_0=0xA5.
- Back-to-back writes: addr=0x04 data=0x80, then addr=0x02 data=0xFF, start held high -> two frames separated by ≥8 clk of nCS high; pwm_duty_cycle=0x80, en_reg_pwm_7_0=0xFF.
- rw=0, addr=0x01, wdata=0x3C -> full 16-clock frame; peripheral en_reg_out_15_8 unchanged (0x00).
- CIPO driven with 0x5A during data bits -> rdata=0x5A at the done cycle; rdata unchanged during the next frame until its completion.
- start pulsed while busy=1 -> ignored; exactly one frame and one done pulse.
- rst asserted at the 7th SCLK rise -> same cycle nCS=1, SCLK=0, busy=0, no done; next start produces a clean full frame.
